// File: rtl/scoreboard_stall_pkg.sv
// hazard_pkg: register index width, standard latencies and the sticky-latency encoding.
package hazard_pkg;
  localparam int REG_IDX_W = 5;
  localparam int LAT_ALU = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_MUL = 2;
  function automatic int lat_sticky(input int lat_w);
    return (1 << lat_w) - 1;
  endfunction
endpackage

// File: rtl/scoreboard_stall_if.sv
// scoreboard_stall_if: ID bundle, writeback and issue/stall signals; STALL_PERF_CNT_EN adds perf counters.
interface scoreboard_stall_if import hazard_pkg::*; #(
  parameter int ISSUE_W = 2,
  parameter int NREG = 32,
  parameter int LAT_W = 3
);
  logic [ISSUE_W-1:0] id_valid, id_rs2_late, id_we, id_issue;
  logic [ISSUE_W*REG_IDX_W-1:0] id_rs1, id_rs2, id_rd;
  logic [ISSUE_W*LAT_W-1:0] id_lat;
  logic flush, wb_valid, id_stall;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [NREG-1:0] sb_busy;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_split_cyc;
  modport master (output id_valid, id_rs1, id_rs2, id_rs2_late, id_we, id_rd, id_lat, flush, wb_valid, wb_rd,
                  input id_issue, id_stall, sb_busy, perf_stall_cyc, perf_split_cyc);
  modport slave (input id_valid, id_rs1, id_rs2, id_rs2_late, id_we, id_rd, id_lat, flush, wb_valid, wb_rd,
                 output id_issue, id_stall, sb_busy, perf_stall_cyc, perf_split_cyc);
`else
  modport master (output id_valid, id_rs1, id_rs2, id_rs2_late, id_we, id_rd, id_lat, flush, wb_valid, wb_rd,
                  input id_issue, id_stall, sb_busy);
  modport slave (input id_valid, id_rs1, id_rs2, id_rs2_late, id_we, id_rd, id_lat, flush, wb_valid, wb_rd,
                 output id_issue, id_stall, sb_busy);
`endif
endinterface

// File: rtl/scoreboard_stall_sb_counter.sv
// sb_counter: one register's pending-write countdown; the all-ones value holds until writeback.
module sb_counter import hazard_pkg::*; #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic [LAT_W-1:0] set_val,
  input  logic             clr,
  input  logic             dec,
  output logic             busy
);
  localparam logic [LAT_W-1:0] STICKY = LAT_W'(lat_sticky(LAT_W));
  logic [LAT_W-1:0] cnt, dec_v, base, nxt;
  always_comb begin
    dec_v = (cnt == STICKY || cnt == '0) ? cnt : cnt - LAT_W'(1);
    base = dec ? dec_v : cnt;
    nxt = set ? ((set_val == STICKY || set_val > base) ? set_val : base) : clr ? '0 : base;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= nxt;
  assign busy = |cnt;
endmodule

// File: rtl/scoreboard_stall.sv
// scoreboard_stall: in-order prefix issue against a countdown scoreboard and intra-bundle RAW.
// Define STALL_PERF_CNT_EN to add the perf_stall_cyc / perf_split_cyc counters.
module scoreboard_stall import hazard_pkg::*; #(
  parameter int ISSUE_W = 2,
  parameter int NREG = 32,
  parameter int LAT_W = 3
) (
  input logic clk,
  input logic rst_n,
  scoreboard_stall_if.slave bus
);
  logic [REG_IDX_W-1:0] rs1_s [ISSUE_W];
  logic [REG_IDX_W-1:0] rs2_s [ISSUE_W];
  logic [REG_IDX_W-1:0] rd_s [ISSUE_W];
  logic [LAT_W-1:0] lat_s [ISSUE_W];
  logic [NREG-1:0] busy;
  logic [ISSUE_W-1:0] blocked, issue;
  logic pre;
  logic [NREG-1:1] set_r, clr_r;
  logic [LAT_W-1:0] set_v [NREG-1:1];
  for (genvar g = 0; g < ISSUE_W; g++) begin : g_slot
    assign rs1_s[g] = bus.id_rs1[g*REG_IDX_W +: REG_IDX_W];
    assign rs2_s[g] = bus.id_rs2[g*REG_IDX_W +: REG_IDX_W];
    assign rd_s[g] = bus.id_rd[g*REG_IDX_W +: REG_IDX_W];
    assign lat_s[g] = bus.id_lat[g*LAT_W +: LAT_W];
  end
  // busy[0] is tied low, so x0 sources never hazard
  always_comb begin
    blocked = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      blocked[i] = busy[rs1_s[i]] | (~bus.id_rs2_late[i] & busy[rs2_s[i]]);
      for (int k = 0; k < i; k++)
        blocked[i] = blocked[i] | (bus.id_valid[k] & bus.id_we[k] & (|rd_s[k]) &
                     ((rd_s[k] == rs1_s[i]) | (~bus.id_rs2_late[i] & (rd_s[k] == rs2_s[i]))));
      blocked[i] = blocked[i] & bus.id_valid[i];
    end
  end
  always_comb begin
    pre = 1'b1;
    issue = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      pre = pre & ~blocked[i];
      issue[i] = bus.id_valid[i] & pre & ~bus.flush;
    end
  end
  // ascending slot order lets the youngest writer win on WAW
  always_comb begin
    set_r = '0;
    for (int r = 1; r < NREG; r++) set_v[r] = '0;
    for (int r = 1; r < NREG; r++)
      for (int i = 0; i < ISSUE_W; i++)
        if (issue[i] && bus.id_we[i] && rd_s[i] == REG_IDX_W'(r)) begin
          set_r[r] = 1'b1;
          set_v[r] = lat_s[i];
        end
  end
  assign busy[0] = 1'b0;
  for (genvar g = 1; g < NREG; g++) begin : g_reg
    assign clr_r[g] = bus.wb_valid & (bus.wb_rd == REG_IDX_W'(g));
    sb_counter #(.LAT_W(LAT_W)) u_cnt (
      .clk(clk), .rst_n(rst_n), .set(set_r[g]), .set_val(set_v[g]),
      .clr(clr_r[g]), .dec(1'b1), .busy(busy[g])
    );
  end
  assign bus.id_issue = issue;
  assign bus.id_stall = |(bus.id_valid & ~issue);
  assign bus.sb_busy = busy;
`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.perf_stall_cyc <= '0;
      bus.perf_split_cyc <= '0;
    end else begin
      if (bus.id_stall && !bus.flush) bus.perf_stall_cyc <= bus.perf_stall_cyc + 32'd1;
      if (bus.id_stall && |issue) bus.perf_split_cyc <= bus.perf_split_cyc + 32'd1;
    end
`endif
endmodule

// File: tb/tb_scoreboard_stall.sv
// tb_scoreboard_stall: directed vectors, expected issue/stall/busy queued and checked by a negedge monitor.
module tb_scoreboard_stall;
  logic clk, rst_n;
  scoreboard_stall_if #(.ISSUE_W(2), .NREG(32), .LAT_W(3)) bus ();
  scoreboard_stall #(.ISSUE_W(2), .NREG(32), .LAT_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int id;
    logic [1:0] issue;
    logic stall;
    logic [31:0] mask;
    logic [31:0] busy;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_fail = 0, vec_id = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bm(input int r);
    return 32'd1 << r;
  endfunction

  task automatic clear_in();
    bus.id_valid = '0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs2_late = '0;
    bus.id_we = '0; bus.id_rd = '0; bus.id_lat = '0;
    bus.flush = 1'b0; bus.wb_valid = 1'b0; bus.wb_rd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic slot(input int i, input int rs1, input int rs2, input bit late,
                      input bit we, input int rd, input int lat);
    bus.id_valid[i] = 1'b1;
    bus.id_rs1[i*5 +: 5] = rs1[4:0];
    bus.id_rs2[i*5 +: 5] = rs2[4:0];
    bus.id_rs2_late[i] = late;
    bus.id_we[i] = we;
    bus.id_rd[i*5 +: 5] = rd[4:0];
    bus.id_lat[i*3 +: 3] = lat[2:0];
  endtask

  task automatic exp_push(input logic [1:0] iss, input logic st, input logic [31:0] m, input logic [31:0] b);
    q.push_back('{vec_id, iss, st, m, b});
    vec_id++;
  endtask

  always @(negedge clk)
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if (bus.id_issue !== e.issue || bus.id_stall !== e.stall || (bus.sb_busy & e.mask) !== (e.busy & e.mask)) begin
        n_fail++;
        $display("FAIL vec%0d: got issue=%b stall=%b busy=%h, required issue=%b stall=%b busy=%h (mask %h)",
                 e.id, bus.id_issue, bus.id_stall, bus.sb_busy & e.mask, e.issue, e.stall, e.busy & e.mask, e.mask);
      end
    end

  initial begin
    rst_n = 1'b0;
    clear_in();
    tick(); slot(0, 1, 2, 0, 1, 3, 0); exp_push(2'b01, 0, '1, '0);
    tick(); rst_n = 1'b1; exp_push(2'b00, 0, '1, '0);
    // load-use
    tick(); slot(0, 1, 2, 0, 1, 5, 1); exp_push(2'b01, 0, bm(5), 0);
    tick(); slot(0, 5, 1, 0, 1, 6, 0); exp_push(2'b00, 1, bm(5), bm(5));
    tick(); slot(0, 5, 1, 0, 1, 6, 0); exp_push(2'b01, 0, bm(5), 0);
    // intra-bundle RAW, then repacked
    tick(); slot(0, 1, 2, 0, 1, 3, 0); slot(1, 3, 2, 0, 1, 4, 0); exp_push(2'b01, 1, bm(3), 0);
    tick(); slot(0, 3, 2, 0, 1, 4, 0); exp_push(2'b01, 0, bm(3) | bm(4), 0);
    // late store data ignores hazard on rs2, not on rs1
    tick(); slot(0, 8, 0, 0, 1, 7, 1); exp_push(2'b01, 0, bm(7), 0);
    tick(); slot(0, 8, 7, 1, 0, 0, 0); slot(1, 7, 8, 1, 0, 0, 0); exp_push(2'b01, 1, bm(7), bm(7));
    // sticky div held until writeback
    tick(); slot(0, 1, 2, 0, 1, 9, 7); exp_push(2'b01, 0, bm(9), 0);
    for (int n = 0; n < 20; n++) begin
      tick(); slot(0, 9, 1, 0, 1, 10, 0); exp_push(2'b00, 1, bm(9), bm(9));
    end
    tick(); slot(0, 9, 1, 0, 1, 10, 0); bus.wb_valid = 1'b1; bus.wb_rd = 5'd9; exp_push(2'b00, 1, bm(9), bm(9));
    tick(); slot(0, 9, 1, 0, 1, 10, 0); exp_push(2'b01, 0, bm(9), 0);
    // flush suppresses issue while counters keep counting
    tick(); slot(0, 1, 2, 0, 1, 11, 2); exp_push(2'b01, 0, bm(11), 0);
    tick(); slot(0, 1, 2, 0, 1, 12, 1); slot(1, 1, 2, 0, 1, 13, 1); bus.flush = 1'b1;
    exp_push(2'b00, 1, bm(11) | bm(12) | bm(13), bm(11));
    tick(); exp_push(2'b00, 0, bm(11) | bm(12) | bm(13), bm(11));
    tick(); exp_push(2'b00, 0, bm(11), 0);
    // asynchronous reset mid-count
    tick(); slot(0, 1, 2, 0, 1, 5, 2); exp_push(2'b01, 0, bm(5), 0);
    tick(); rst_n = 1'b0; exp_push(2'b00, 0, '1, '0);
    tick(); rst_n = 1'b1; exp_push(2'b00, 0, '1, '0);
    // WAW inside a bundle: younger slot's latency wins
    tick(); slot(0, 1, 2, 0, 1, 5, 1); slot(1, 1, 2, 0, 1, 5, 0); exp_push(2'b11, 0, bm(5), 0);
    tick(); slot(0, 5, 1, 0, 1, 6, 0); exp_push(2'b01, 0, bm(5), 0);
    // later shorter write keeps max of decremented count and new latency
    tick(); slot(0, 1, 2, 0, 1, 14, 2); exp_push(2'b01, 0, bm(14), 0);
    tick(); slot(0, 1, 2, 0, 1, 14, 1); exp_push(2'b01, 0, bm(14), bm(14));
    tick(); exp_push(2'b00, 0, bm(14), bm(14));
    tick(); exp_push(2'b00, 0, bm(14), 0);
    for (int w = 0; w < 4 && q.size() > 0; w++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/scoreboard_stall.md
Name: scoreboard_stall

Overview:
- Parametrised successor to the two-issue load-use stall logic, for an ISSUE_W-wide in-order RISC-V pipeline.
- Holds a per-register countdown scoreboard of pending writes (loads, multi-cycle mul, variable-latency div).
- Each cycle it decides which in-order prefix of the ID bundle may issue, covering scoreboard hazards and intra-bundle RAW.
- Sits between ID and EX; drives ID stall and upstream bundle hold.

Parameters:
- ISSUE_W, 2, number of issue slots per bundle.
- NREG, 32, architectural registers; x0 is never tracked.
- LAT_W, 3, counter width. Value 2^LAT_W-1 (LAT_STICKY) means "wait for writeback".

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  ISSUE_W  slot i holds an instruction.
- id_rs1  in  ISSUE_W*5  rs1 per slot.
- id_rs2  in  ISSUE_W*5  rs2 per slot.
- id_rs2_late  in  ISSUE_W  rs2 is consumed at MEM (store data); ignored for hazards.
- id_we  in  ISSUE_W  slot writes rd.
- id_rd  in  ISSUE_W*5  destination per slot.
- id_lat  in  ISSUE_W*LAT_W  cycles until result is bypassable. 0 = ALU, 1 = load, LAT_STICKY = div.
- flush  in  1  pipeline flush this cycle.
- wb_valid  in  1  variable-latency unit writes back.
- wb_rd  in  5  its destination.
- id_issue  out  ISSUE_W  slots issuing this cycle; always a contiguous prefix.
- id_stall  out  1  some valid slot did not issue.
- sb_busy  out  NREG  cnt[r] != 0, for debug.

Behaviour:
- State: cnt[r], LAT_W bits, r = 1..NREG-1. Reset (async, rst_n=0): all cnt = 0. Outputs are combinational from state and inputs, so after reset id_issue = id_valid and id_stall = 0.
- Source hazard for slot i, source r: r != 0 and cnt[r] != 0. Sources checked: rs1 always; rs2 only when id_rs2_late[i] = 0.
- Intra-bundle hazard for slot j: a source of j equals id_rd[k] for some k < j with id_valid[k], id_we[k], and id_rd[k] != 0. Latency does not matter here; same-cycle bypass is not supported.
- Blocked slot: id_valid[i] and (source hazard or intra-bundle hazard). Invalid slots are never blocked.
- id_issue[i] = id_valid[i] and no slot 0..i is blocked. id_issue is forced to 0 while flush = 1.
- id_stall = OR of (id_valid & ~id_issue). Upstream holds and repacks unissued slots.
- Per register, next-state priority (highest first):
  - Issue: some issuing slot writes r. Use the highest-index such slot (WAW within the bundle) with latency L. If L = LAT_STICKY, cnt = LAT_STICKY. Otherwise cnt = max(dec(cnt), L).
  - Writeback: wb_valid and wb_rd = r, with no issue to r. cnt = 0.
  - Otherwise: cnt = dec(cnt).
  - dec(x): LAT_STICKY stays LAT_STICKY; 0 stays 0; any other value becomes x-1.
- Timing: a producer with L = 1 issues at cycle t. A dependent instruction in ID at t+1 stalls and issues at t+2 (one bubble). L = 0 never stalls.
- wb_rd = 0 is ignored. wb to a register with a non-sticky count clears it; this is harmless.
- Flush: suppresses issue only. Counters keep counting, which is conservative. A sticky entry from a squashed div is cleared by its wb, which the div unit must still emit.
- Mid-operation reset clears all counters immediately.

Optional Feature:
- STALL_PERF_CNT_EN defined: adds outputs perf_stall_cyc[31:0] and perf_split_cyc[31:0].
  - perf_stall_cyc increments when id_stall = 1 and flush = 0.
  - perf_split_cyc increments when id_stall = 1 and id_issue != 0.
  - Both reset to 0 and wrap at 2^32.
- Undefined: neither port nor any counter exists.

Decomposition:
- Package hazard_pkg holds REG_IDX_W = 5, LAT_ALU = 0, LAT_LOAD = 1, LAT_MUL = 2, and the LAT_STICKY function of LAT_W.
- Sub-module sb_counter: one register's counter. Inputs set, set_val, clr, dec; output busy. Instantiated via generate for r = 1..NREG-1.
- Combinational prefix/issue logic lives in the top.

Test Plan:
1. Load-use: slot0 lw x5 (L=1) issues at t; at t+1 slot0 add x6,x5,x1 -> id_issue=00, id_stall=1. At t+2 -> id_issue=01.
2. Intra-bundle: slot0 add x3 (L=0), slot1 sub x4,x3,x2 -> id_issue=01, id_stall=1. Next cycle, slot1 moved to slot0 -> issues with no stall.
3. Store data late: in-flight lw x7 (cnt=1); sw x7,0(x8) with id_rs2_late=1 -> issues. sw x8,0(x7) -> stalls.
4. Sticky div: div x9 with L=7 -> cnt[9]=7 holds for 20 cycles and consumers stall. wb_valid=1, wb_rd=9 -> sb_busy[9]=0 next cycle, consumer issues.
5. Flush and reset: flush=1 with a valid hazard-free bundle -> id_issue=00, scoreboard unchanged. rst_n low mid-count with cnt[5]=2 -> sb_busy=0 immediately.
6. WAW: lw x5 (L=1) and add x5 (L=0) in the same bundle, both issuing -> cnt[5]=0 (slot1 wins). Separately, L=2 then an L=1 write to the same register one cycle later -> cnt = max(1,1) = 1.
